pc_flag_ctrl: RTL
=================

# pc_flag_ctrl

Program-counter and condition-flag control for the 16-bit single-cycle core. Sits downstream of the ALU and upstream of instruction fetch. Holds the PC and the N/V/Z flag register, and updates the flags from ALU results per opcode. Resolves B/BR branch conditions against the stored flags, provides PC+2 to PCS writeback, and owns the run/halt state machine.

## Interface
- No parameters; data width is fixed at 16.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction currently executing; [15:12] opcode, [11:9] ccc, [8:0] branch immediate.
- stall  in  1  high: hold all state for this cycle.
- br_reg  in  16  rs value read for BR.
- alu_result  in  16  ALU output for the current instruction.
- alu_flags  in  3  ALU flags; [2]=N, [1]=V, [0]=Z (Z unused, see Operation).
- pc  out  16  registered PC, used as the fetch address.
- pc_plus2  out  16  pc+2, combinational; used for PCS writeback and the branch base.
- flags  out  3  registered {N,V,Z}.
- branch_taken  out  1  combinational; high when the current B/BR will redirect.
- halted  out  1  registered; high in HALT.

## Operation
- States: RUN and HALT (1-bit state register).
- RUN to HALT when the opcode is 1111, stall is 0, and a rising edge occurs.
- HALT has no exit except rst_n.
- next_pc:
  - B (1100) taken: pc_plus2 + (sext9(instr[8:0]) << 1).
  - BR (1101) taken: br_reg with bit 0 forced to 0.
  - HLT: pc (no change).
  - Otherwise: pc_plus2.
- All PC arithmetic is modulo 2^16; 0xFFFE+2 = 0x0000. Offsets wrap silently.
- Branch condition on ccc, evaluated against the registered flags, never the current ALU flags:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 always taken
- branch_taken is 0 for any opcode other than B/BR, and 0 in HALT.
- Flag writes:
  - ADD (0000) and SUB (0001) write all of N, V, Z.
  - XOR (0011), SLL (0100), SRA (0101), ROR (0110) write Z only; N and V hold.
  - All other opcodes leave flags unchanged.
- Z is always computed internally as (alu_result == 0). N = alu_flags[2], V = alu_flags[1].

## Timing
- Reset (asynchronous assert): pc=0x0000, flags=3'b000, state=RUN, halted=0.
- Reset release: the first update occurs on the first rising edge with rst_n high.
- Latency: next_pc and flag writes take effect at the rising edge that ends the instruction's cycle. A flag-setting instruction followed by a branch uses the new flags.
- stall=1: pc, flags, and state all hold; stall takes priority over HLT, branch, and flag writes.
- In HALT, pc, flags, and halted hold regardless of instr and stall; pc stays at the HLT's address.
- Reset asserted mid-cycle or while halted returns to the reset values immediately.
- pc_plus2 and branch_taken are combinational from pc, flags, and instr, with no added cycle.

## Structure
- Shared package/include cpu_defs:
  - 4-bit opcode constants (ADD…HLT).
  - 3-bit condition codes.
  - Flag bit indices FLAG_N=2, FLAG_V=1, FLAG_Z=0.
  - Reset vector 16'h0000.
- Sub-module branch_cond: combinational (ccc, flags) -> take. It is also reused by the verification model.
- Top level contains the PC register, flag register, state register, and the next-PC mux.

## Test plan
- Reset then 3 non-branch instrs (ADD with nonzero result) -> pc = 0x0000, 0x0002, 0x0004, 0x0006; halted=0.
- SUB with alu_result=0, alu_flags=3'b000, then B ccc=001 imm=9'h1FE at pc=0x0010 -> flags=001; branch_taken=1; next pc = 0x0012 + 0xFFFC = 0x000E.
- flags=3'b110, then XOR with result 0x0000 -> flags=3'b111 (N,V held, Z set). Then B ccc=010 -> not taken; pc += 2.
- BR ccc=111 with br_reg=0x1235 -> pc = 0x1234. PCS at pc=0xFFFE -> pc_plus2 = 0x0000 and pc wraps to 0x0000.
- HLT with stall=1 for 2 cycles -> pc holds, halted=0. Then stall=0 -> halted=1; pc stays at the HLT address for 5+ cycles despite ADD/B on instr.
- Assert rst_n low mid-cycle while halted, flags=111, pc=0x0040 -> pc=0, flags=0, halted=0 before the next clock edge.

Source files
------------

// File: rtl/pc_flag_ctrl_pkg.sv
// Shared core definitions: opcodes, condition codes, flag bit positions,
// reset vector and run/halt state encoding.
package pc_flag_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] CC_NE   = 3'b000;
    localparam logic [2:0] CC_EQ   = 3'b001;
    localparam logic [2:0] CC_GT   = 3'b010;
    localparam logic [2:0] CC_LT   = 3'b011;
    localparam logic [2:0] CC_GTE  = 3'b100;
    localparam logic [2:0] CC_LTE  = 3'b101;
    localparam logic [2:0] CC_OVFL = 3'b110;
    localparam logic [2:0] CC_ALW  = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    localparam logic [15:0] RESET_VECTOR = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Branch immediate is a signed halfword count; scale to a byte offset.
    function automatic logic [15:0] branch_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/pc_flag_ctrl_branch_cond.sv
// Branch condition evaluation of a 3-bit condition code against stored {N,V,Z}.
module pc_flag_ctrl_branch_cond
    import pc_flag_ctrl_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       take
);

    logic n_s;
    logic v_s;
    logic z_s;

    assign n_s = flags[FLAG_N];
    assign v_s = flags[FLAG_V];
    assign z_s = flags[FLAG_Z];

    // Condition decode.
    always_comb begin
        take = 1'b0;
        case (ccc)
            CC_NE:   take = ~z_s;
            CC_EQ:   take = z_s;
            CC_GT:   take = ~z_s & ~n_s;
            CC_LT:   take = n_s;
            CC_GTE:  take = z_s | ~n_s;
            CC_LTE:  take = n_s | z_s;
            CC_OVFL: take = v_s;
            CC_ALW:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_ctrl.sv
// PC, condition flags and run/halt control for the 16-bit single-cycle core.
module pc_flag_ctrl
    import pc_flag_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        stall,
    input  logic [15:0] br_reg,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [2:0]  flags,
    output logic        branch_taken,
    output logic        halted
);

    state_e      state_r;
    state_e      next_state_s;
    logic [15:0] pc_r;
    logic [15:0] next_pc_s;
    logic [2:0]  flags_r;
    logic [2:0]  next_flags_s;
    logic [3:0]  opcode_s;
    logic        cond_s;
    logic        z_s;
    logic [2:0]  nv_mask_s;

    assign opcode_s  = instr[15:12];
    assign pc_plus2  = pc_r + 16'd2;
    assign z_s       = (alu_result == 16'h0000);
    // Z comes from the result, never from the ALU's own Z bit.
    assign nv_mask_s = alu_flags & 3'b110;

    pc_flag_ctrl_branch_cond u_branch_cond (
        .ccc   (instr[11:9]),
        .flags (flags_r),
        .take  (cond_s)
    );

    // Branch redirect decision; conditions use registered flags only.
    always_comb begin
        branch_taken = 1'b0;
        if ((state_r == ST_RUN) && ((opcode_s == OP_B) || (opcode_s == OP_BR))) begin
            branch_taken = cond_s;
        end else begin
            branch_taken = 1'b0;
        end
    end

    // Next-PC mux.
    always_comb begin
        next_pc_s = pc_plus2;
        case (opcode_s)
            OP_B: begin
                if (branch_taken) begin
                    next_pc_s = pc_plus2 + branch_offset(instr[8:0]);
                end else begin
                    next_pc_s = pc_plus2;
                end
            end
            OP_BR: begin
                if (branch_taken) begin
                    next_pc_s = br_reg & 16'hFFFE;
                end else begin
                    next_pc_s = pc_plus2;
                end
            end
            OP_HLT:  next_pc_s = pc_r;
            default: next_pc_s = pc_plus2;
        endcase
    end

    // Flag update per opcode class.
    always_comb begin
        next_flags_s = flags_r;
        case (opcode_s)
            OP_ADD, OP_SUB:                 next_flags_s = nv_mask_s | {2'b00, z_s};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: next_flags_s = {flags_r[2:1], z_s};
            default:                        next_flags_s = flags_r;
        endcase
    end

    // Run/halt next state; HALT only leaves through reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (opcode_s == OP_HLT) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_RUN;
        endcase
    end

    // Architectural state; stall and HALT both freeze everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_VECTOR;
            flags_r <= 3'b000;
            state_r <= ST_RUN;
        end else if (!stall && (state_r == ST_RUN)) begin
            pc_r    <= next_pc_s;
            flags_r <= next_flags_s;
            state_r <= next_state_s;
        end else begin
            pc_r    <= pc_r;
            flags_r <= flags_r;
            state_r <= state_r;
        end
    end

    assign pc     = pc_r;
    assign flags  = flags_r;
    assign halted = (state_r == ST_HALT);

endmodule
